// File: rtl/lut_input_packer_if.sv
// Handshake bundle for lut_input_packer: raw samples in, packed 2-bit code vectors out.
interface lut_input_packer_if #(
  parameter int NUM_FEAT = 8,
  parameter int IN_W     = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [IN_W-1:0]       s_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [2*NUM_FEAT-1:0] m_data;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/lut_input_packer.sv
// Quantizes raw feature samples to 2-bit codes and packs NUM_FEAT of them per output vector.
// Optional frame checking of s_last against the slot index: define PACKER_LAST_CHECK_EN.
module lut_input_packer #(
  parameter int NUM_FEAT = 8,
  parameter int IN_W     = 8,
  parameter int TH0      = 64,
  parameter int TH1      = 128,
  parameter int TH2      = 192
) (
  input  logic              clk,
  input  logic              rst_n,
  lut_input_packer_if.slave bus,
  output logic              err
);
  localparam int VEC_W = 2 * NUM_FEAT;
  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam logic [IN_W-1:0]  TH0_Q    = IN_W'(TH0);
  localparam logic [IN_W-1:0]  TH1_Q    = IN_W'(TH1);
  localparam logic [IN_W-1:0]  TH2_Q    = IN_W'(TH2);

`ifdef PACKER_LAST_CHECK_EN
  localparam bit LAST_CHECK = 1'b1;
`else
  localparam bit LAST_CHECK = 1'b0;
`endif

  typedef enum logic {COLLECT, EMIT} state_t;

  // Code is the number of thresholds the sample reaches; ordered thresholds keep it in 0..3.
  function automatic logic [1:0] quantize(input logic [IN_W-1:0] x);
    logic [1:0] c;
    c = {1'b0, (x >= TH0_Q)} + {1'b0, (x >= TH1_Q)} + {1'b0, (x >= TH2_Q)};
    return c;
  endfunction

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [VEC_W-1:0] slots;
  logic             s_ready_r;
  logic             m_valid_r;
  logic [VEC_W-1:0] m_data_r;
  logic             err_r;

  logic [1:0]       code_p0;
  logic [VEC_W-1:0] packed_p0;

  // Stage 0: current sample's code merged into the partial vector at slot idx
  assign code_p0 = quantize(bus.s_data);

  always_comb begin
    packed_p0                     = slots;
    packed_p0[{idx, 1'b0} +: 2]   = code_p0;
  end

  // Stage 1: registered FSM, slot storage and all outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= '0;
      slots     <= '0;
      s_ready_r <= 1'b1;
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      err_r     <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state)
        COLLECT: begin
          if (bus.s_valid) begin
            if (idx == LAST_IDX) begin
              state     <= EMIT;
              s_ready_r <= 1'b0;
              m_valid_r <= 1'b1;
              m_data_r  <= packed_p0;
              idx       <= '0;
              slots     <= '0;
              err_r     <= LAST_CHECK && !bus.s_last;
            end else if (LAST_CHECK && bus.s_last) begin
              // Short frame: drop what was collected and start over.
              idx   <= '0;
              slots <= '0;
              err_r <= 1'b1;
            end else begin
              slots <= packed_p0;
              idx   <= idx + 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.m_ready) begin
            state     <= COLLECT;
            s_ready_r <= 1'b1;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.s_ready = s_ready_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = m_data_r;
  assign err         = err_r;

endmodule

// File: tb/tb_lut_input_packer.sv
// Randomized and directed bench for lut_input_packer against a frame-level reference model.
module tb_lut_input_packer;
  localparam int NF = 8;
  localparam int IW = 8;
  localparam int T0 = 64;
  localparam int T1 = 128;
  localparam int T2 = 192;
  localparam int VW = 2 * NF;

`ifdef PACKER_LAST_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic err;

  lut_input_packer_if #(.NUM_FEAT(NF), .IN_W(IW)) bus();

  lut_input_packer #(
    .NUM_FEAT(NF), .IN_W(IW), .TH0(T0), .TH1(T1), .TH2(T2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .err  (err)
  );

  always #5 clk = ~clk;

  // Reference model: list of codes collected so far, pending vector, expected err pulse.
  int             mcodes[NF];
  int             mcnt = 0;
  bit             pend = 1'b0;
  logic [VW-1:0]  mvec = '0;
  bit             merr = 1'b0;
  int             mxfers = 0;

  int             n_pass = 0;
  int             n_total = 0;
  int             cyc = 0;
  bit             prev_mv = 1'b0;
  int             err_pulses = 0;
  int             rise_cyc[$];
  logic [VW-1:0]  rise_dat[$];
  logic [IW-1:0]  pat[NF] = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};

  function automatic int qz(input logic [IW-1:0] x);
    int c = 0;
    if (int'(x) >= T0) c++;
    if (int'(x) >= T1) c++;
    if (int'(x) >= T2) c++;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Advance the model by the rising edge that just happened, using the inputs present at it.
  task automatic model_step();
    if (!rst_n) begin
      mcnt = 0; pend = 1'b0; mvec = '0; merr = 1'b0;
    end else begin
      merr = 1'b0;
      if (!pend) begin
        if (bus.s_valid) begin
          mcodes[mcnt] = qz(bus.s_data);
          mcnt++;
          if (mcnt == NF) begin
            mvec = '0;
            for (int i = 0; i < NF; i++) mvec = mvec + VW'(mcodes[i] * (4 ** i));
            pend = 1'b1;
            mcnt = 0;
            merr = CHECK && !bus.s_last;
          end else if (CHECK && bus.s_last) begin
            mcnt = 0;
            merr = 1'b1;
          end
        end
      end else if (bus.m_ready) begin
        pend = 1'b0;
        mxfers++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    chk("s_ready", {31'd0, bus.s_ready}, {31'd0, !pend});
    chk("m_valid", {31'd0, bus.m_valid}, {31'd0, pend});
    chk("m_data",  32'(bus.m_data), 32'(pend ? mvec : '0));
    chk("err",     {31'd0, err}, {31'd0, merr});
    if (bus.m_valid && !prev_mv) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back(bus.m_data);
    end
    if (err) err_pulses++;
    prev_mv = bus.m_valid;
    cyc++;
  endtask

  task automatic push(input logic [IW-1:0] d, input logic l);
    logic rdy;
    int   n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    do begin
      rdy = bus.s_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    chk("push_accept", {31'd0, rdy}, 32'd1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic clear_rise();
    rise_cyc.delete();
    rise_dat.delete();
  endtask

  initial begin
    int acc;
    int x0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    rst_n       = 1'b0;
    tick();
    tick();
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
    chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_m_data",  32'(bus.m_data), 32'd0);
    chk("rst_err",     {31'd0, err}, 32'd0);
    rst_n = 1'b1;

    // Threshold boundary frame, downstream always ready
    bus.m_ready = 1'b1;
    clear_rise();
    for (int i = 0; i < NF; i++) push(pat[i], i == NF - 1);
    acc = cyc - 1;
    chk("fa50_vec",   32'(bus.m_data), 32'h0000FA50);
    chk("fa50_valid", {31'd0, bus.m_valid}, 32'd1);
    chk("fa50_err",   {31'd0, err}, 32'd0);
    chk("fa50_lat",   (rise_cyc.size() > 0) ? rise_cyc[0] : -1, acc);
    tick();
    chk("fa50_taken", {31'd0, bus.m_valid}, 32'd0);

    // Same frame with downstream stalled for 5 cycles
    bus.m_ready = 1'b0;
    for (int i = 0; i < NF; i++) push(pat[i], i == NF - 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_m_valid", {31'd0, bus.m_valid}, 32'd1);
      chk("stall_m_data",  32'(bus.m_data), 32'h0000FA50);
      chk("stall_s_ready", {31'd0, bus.s_ready}, 32'd0);
    end
    x0 = mxfers;
    bus.m_ready = 1'b1;
    tick();
    chk("stall_release", {31'd0, bus.m_valid}, 32'd0);
    tick();
    chk("stall_one_xfer", mxfers - x0, 32'd1);

    // Back-to-back frames: all-255 then all-0
    clear_rise();
    for (int i = 0; i < NF; i++) push(8'd255, i == NF - 1);
    for (int i = 0; i < NF; i++) push(8'd0, i == NF - 1);
    tick();
    chk("b2b_count", rise_cyc.size(), 32'd2);
    if (rise_cyc.size() >= 2) begin
      chk("b2b_vec0", 32'(rise_dat[0]), 32'h0000FFFF);
      chk("b2b_vec1", 32'(rise_dat[1]), 32'h00000000);
      chk("b2b_gap",  rise_cyc[1] - rise_cyc[0], 32'd9);
    end

    // Asynchronous reset while a vector is pending
    bus.m_ready = 1'b0;
    for (int i = 0; i < NF; i++) push(8'd255, i == NF - 1);
    rst_n = 1'b0;
    #1;
    chk("async_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("async_m_data",  32'(bus.m_data), 32'd0);
    chk("async_s_ready", {31'd0, bus.s_ready}, 32'd1);
    tick();
    rst_n = 1'b1;

    // Reset mid-frame, then a full frame of 255
    bus.m_ready = 1'b1;
    clear_rise();
    for (int i = 0; i < 4; i++) push(8'd100, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NF; i++) push(8'd255, i == NF - 1);
    tick();
    tick();
    chk("midrst_count", rise_cyc.size(), 32'd1);
    if (rise_cyc.size() >= 1) chk("midrst_vec", 32'(rise_dat[0]), 32'h0000FFFF);

    // Short frame (s_last on 3rd sample), then a full frame of 128
    clear_rise();
    err_pulses = 0;
    push(8'd255, 1'b0);
    push(8'd255, 1'b0);
    push(8'd255, 1'b1);
    chk("short_err", {31'd0, err}, CHECK ? 32'd1 : 32'd0);
    for (int i = 0; i < NF; i++) push(8'd128, i == NF - 1);
    tick();
    tick();
    chk("short_count", rise_cyc.size(), 32'd1);
    if (rise_cyc.size() >= 1) chk("short_vec", 32'(rise_dat[0]), CHECK ? 32'h0000AAAA : 32'h0000AABF);
    chk("short_err_pulses", err_pulses, CHECK ? 32'd1 : 32'd0);

    // Clean slate, then randomized traffic with occasional resets
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.s_data  = IW'($urandom);
      bus.s_last  = ($urandom_range(0, 7) == 0);
      bus.m_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
